// File: rtl/instr_fetch_unit.sv
// Instruction fetch: drives word reads from the PC, buffers returned words in a DEPTH-entry prefetch FIFO for decode.
// A consumed response is visible at the head one cycle later (no bypass); reads stop while the FIFO is full or out_ready holds it there.
module instr_fetch_unit #(
    parameter int                 ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int                 DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_rd_en,
    input  logic [31:0]       imem_instr,
    input  logic              imem_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              out_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, FULL} state_t;

    state_t            r_state;
    logic              r_rd_en;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_fifo_instr [DEPTH];
    logic [ADDR_W-1:0] r_fifo_pc    [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_push;
    logic              w_pop;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              w_room;

    // A redirect kills both the response landing this edge and any pop.
    assign w_push      = r_rd_en && imem_ready && !redirect_valid;
    assign w_pop       = (r_count != '0) && out_ready && !redirect_valid;
    assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_room      = (w_count_nxt < FULL_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_rd_en  <= 1'b0;
            r_pc     <= RESET_PC;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_instr[i] <= '0;
                r_fifo_pc[i]    <= RESET_PC;
            end
        end else if (redirect_valid) begin
            r_pc     <= redirect_pc;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_state  <= fetch_en ? FETCH : IDLE;
            r_rd_en  <= fetch_en;
        end else begin
            if (w_push) begin
                r_fifo_instr[r_wr_ptr] <= imem_instr;
                r_fifo_pc[r_wr_ptr]    <= r_pc;
                r_wr_ptr               <= r_wr_ptr + 1'b1;
                r_pc                   <= r_pc + 1'b1;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;

            // Entering FETCH requires room after this edge, so every issued read has a free slot.
            case (r_state)
                IDLE: begin
                    if (fetch_en && w_room) begin
                        r_state <= FETCH;
                        r_rd_en <= 1'b1;
                    end
                end
                FETCH: begin
                    if (w_push && !fetch_en) begin
                        r_state <= IDLE;
                        r_rd_en <= 1'b0;
                    end else if (w_push && !w_room) begin
                        r_state <= FULL;
                        r_rd_en <= 1'b0;
                    end
                end
                FULL: begin
                    if (w_room) begin
                        r_state <= fetch_en ? FETCH : IDLE;
                        r_rd_en <= fetch_en;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_rd_en <= 1'b0;
                end
            endcase
        end
    end

    assign imem_addr  = r_pc;
    assign imem_rd_en = r_rd_en;
    assign out_valid  = (r_count != '0);
    assign out_instr  = r_fifo_instr[r_rd_ptr];
    assign out_pc     = r_fifo_pc[r_rd_ptr];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a falling-edge instruction memory (standard or 3-cycle slow).
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rd_en;
    logic [31:0] imem_instr = '0;
    logic        imem_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    bit slow_mem  = 1'b0;
    bit force_rdy = 1'b0;
    int wait_cnt  = 0;

    logic [97:0] obs;
    logic [33:0] obs_s;
    assign obs   = {imem_rd_en, imem_addr, out_valid, out_pc, out_instr};
    assign obs_s = {imem_rd_en, imem_addr, out_valid};

    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
        .imem_addr(imem_addr), .imem_rd_en(imem_rd_en),
        .imem_instr(imem_instr), .imem_ready(imem_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
        .out_ready(out_ready)
    );

    // Memory contents: word at address a is a + 0x100.
    always @(negedge clk) begin
        if (force_rdy) begin
            imem_ready = 1'b1;
            imem_instr = imem_addr + 32'h100;
        end else if (imem_rd_en) begin
            wait_cnt = wait_cnt + 1;
            if (!slow_mem || wait_cnt == 3) begin
                imem_ready = 1'b1;
                imem_instr = imem_addr + 32'h100;
                wait_cnt   = 0;
            end else begin
                imem_ready = 1'b0;
            end
        end else begin
            imem_ready = 1'b0;
            wait_cnt   = 0;
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        slow_mem       = 1'b0;
        force_rdy      = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        logic [97:0] exp;
        rst_n = 1'b0;
        fetch_en = 1'b0;
        #2;
        exp = '0;
        n_checks++;
        if (obs !== exp) $display("FAIL reset_values: got %h want %h", obs, exp);
        else n_pass++;
        apply_reset();
        step();
        n_checks++;
        if (obs_s !== 34'd0) $display("FAIL reset_idle: got %h want %h", obs_s, 34'd0);
        else n_pass++;
    endtask

    task automatic test_stream;
        logic [97:0] exp;
        logic [33:0] exp_s;
        apply_reset();
        fetch_en  = 1'b1;
        out_ready = 1'b1;
        step();
        exp_s = {1'b1, 32'h0, 1'b0};
        n_checks++;
        if (obs_s !== exp_s) $display("FAIL stream_first_issue: got %h want %h", obs_s, exp_s);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            step();
            exp = {1'b1, 32'(i + 1), 1'b1, 32'(i), 32'(i) + 32'h100};
            n_checks++;
            if (obs !== exp) $display("FAIL stream[%0d]: got %h want %h", i, obs, exp);
            else n_pass++;
        end
    endtask

    task automatic test_full;
        logic [97:0] exp;
        apply_reset();
        fetch_en  = 1'b1;
        out_ready = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            exp = {1'b1, 32'(i + 1), 1'b1, 32'h0, 32'h100};
            n_checks++;
            if (obs !== exp) $display("FAIL fill[%0d]: got %h want %h", i, obs, exp);
            else n_pass++;
        end
        step();
        exp = {1'b0, 32'h4, 1'b1, 32'h0, 32'h100};
        n_checks++;
        if (obs !== exp) $display("FAIL full_stop: got %h want %h", obs, exp);
        else n_pass++;
        force_rdy = 1'b1;
        step();
        step();
        n_checks++;
        if (obs !== exp) $display("FAIL full_ready_ignored: got %h want %h", obs, exp);
        else n_pass++;
        force_rdy = 1'b0;
        out_ready = 1'b1;
        step();
        exp = {1'b1, 32'h4, 1'b1, 32'h1, 32'h101};
        n_checks++;
        if (obs !== exp) $display("FAIL full_resume: got %h want %h", obs, exp);
        else n_pass++;
        step();
        exp = {1'b1, 32'h5, 1'b1, 32'h2, 32'h102};
        n_checks++;
        if (obs !== exp) $display("FAIL full_push_pop: got %h want %h", obs, exp);
        else n_pass++;
    endtask

    task automatic test_redirect;
        logic [97:0] exp;
        logic [33:0] exp_s;
        apply_reset();
        fetch_en  = 1'b1;
        out_ready = 1'b0;
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h5;
        step();
        redirect_valid = 1'b0;
        exp_s = {1'b1, 32'h5, 1'b0};
        n_checks++;
        if (obs_s !== exp_s) $display("FAIL redir_first: got %h want %h", obs_s, exp_s);
        else n_pass++;
        step();
        step();
        step();
        exp = {1'b1, 32'h8, 1'b1, 32'h5, 32'h105};
        n_checks++;
        if (obs !== exp) $display("FAIL redir_holding: got %h want %h", obs, exp);
        else n_pass++;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        out_ready      = 1'b1;
        step();
        redirect_valid = 1'b0;
        exp_s = {1'b1, 32'h40, 1'b0};
        n_checks++;
        if (obs_s !== exp_s) $display("FAIL redir_flush: got %h want %h", obs_s, exp_s);
        else n_pass++;
        step();
        exp = {1'b1, 32'h41, 1'b1, 32'h40, 32'h140};
        n_checks++;
        if (obs !== exp) $display("FAIL redir_target0: got %h want %h", obs, exp);
        else n_pass++;
        step();
        exp = {1'b1, 32'h42, 1'b1, 32'h41, 32'h141};
        n_checks++;
        if (obs !== exp) $display("FAIL redir_target1: got %h want %h", obs, exp);
        else n_pass++;
    endtask

    task automatic test_slow_mem;
        logic [97:0] exp;
        logic [33:0] exp_s;
        apply_reset();
        slow_mem  = 1'b1;
        fetch_en  = 1'b1;
        out_ready = 1'b1;
        step();
        for (int w = 0; w < 3; w++) begin
            for (int k = 0; k < 2; k++) begin
                step();
                exp_s = {1'b1, 32'(w), 1'b0};
                n_checks++;
                if (obs_s !== exp_s) $display("FAIL slow_wait[%0d.%0d]: got %h want %h", w, k, obs_s, exp_s);
                else n_pass++;
            end
            step();
            exp = {1'b1, 32'(w + 1), 1'b1, 32'(w), 32'(w) + 32'h100};
            n_checks++;
            if (obs !== exp) $display("FAIL slow_word[%0d]: got %h want %h", w, obs, exp);
            else n_pass++;
        end
        fetch_en = 1'b0;
        step();
        step();
        exp_s = {1'b1, 32'h3, 1'b0};
        n_checks++;
        if (obs_s !== exp_s) $display("FAIL drop_outstanding: got %h want %h", obs_s, exp_s);
        else n_pass++;
        step();
        exp = {1'b0, 32'h4, 1'b1, 32'h3, 32'h103};
        n_checks++;
        if (obs !== exp) $display("FAIL drop_complete: got %h want %h", obs, exp);
        else n_pass++;
        step();
        step();
        exp_s = {1'b0, 32'h4, 1'b0};
        n_checks++;
        if (obs_s !== exp_s) $display("FAIL drop_idle: got %h want %h", obs_s, exp_s);
        else n_pass++;
        slow_mem = 1'b0;
    endtask

    task automatic test_wrap;
        logic [97:0] exp;
        logic [33:0] exp_s;
        apply_reset();
        fetch_en  = 1'b1;
        out_ready = 1'b1;
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        step();
        redirect_valid = 1'b0;
        exp_s = {1'b1, 32'hFFFF_FFFE, 1'b0};
        n_checks++;
        if (obs_s !== exp_s) $display("FAIL wrap_start: got %h want %h", obs_s, exp_s);
        else n_pass++;
        step();
        exp = {1'b1, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_00FE};
        n_checks++;
        if (obs !== exp) $display("FAIL wrap_fe: got %h want %h", obs, exp);
        else n_pass++;
        step();
        exp = {1'b1, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'h0000_00FF};
        n_checks++;
        if (obs !== exp) $display("FAIL wrap_ff: got %h want %h", obs, exp);
        else n_pass++;
        step();
        exp = {1'b1, 32'h1, 1'b1, 32'h0, 32'h100};
        n_checks++;
        if (obs !== exp) $display("FAIL wrap_zero: got %h want %h", obs, exp);
        else n_pass++;
    endtask

    task automatic test_reset_mid_fetch;
        logic [97:0] exp;
        logic [33:0] exp_s;
        apply_reset();
        fetch_en  = 1'b1;
        out_ready = 1'b0;
        step();
        step();
        step();
        step();
        exp = {1'b1, 32'h3, 1'b1, 32'h0, 32'h100};
        n_checks++;
        if (obs !== exp) $display("FAIL mid_setup: got %h want %h", obs, exp);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        exp = '0;
        n_checks++;
        if (obs !== exp) $display("FAIL mid_async_clear: got %h want %h", obs, exp);
        else n_pass++;
        #3;
        rst_n = 1'b1;
        step();
        exp_s = {1'b1, 32'h0, 1'b0};
        n_checks++;
        if (obs_s !== exp_s) $display("FAIL mid_restart: got %h want %h", obs_s, exp_s);
        else n_pass++;
        step();
        exp = {1'b1, 32'h1, 1'b1, 32'h0, 32'h100};
        n_checks++;
        if (obs !== exp) $display("FAIL mid_first_word: got %h want %h", obs, exp);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_redirect();
        test_slow_mem();
        test_wrap();
        test_reset_mid_fetch();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Initiator side of the instruction-memory read interface: holds the program counter and drives word address and read enable to the instruction memory.
- Captures returned words into a small prefetch FIFO and presents them to decode with a valid/ready handshake.
- Accepts branch/jump redirects from execute, which flush the FIFO and restart fetch at the new PC.

Parameters:
- ADDR_W, 32, width of PC and memory word address.
- RESET_PC, 32'h0000_0000, PC loaded on reset (word address).
- DEPTH, 4, prefetch FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_en  in  1  enables issuing new memory reads.
- imem_addr  out  ADDR_W  word address to instruction memory.
- imem_rd_en  out  1  read request to instruction memory.
- imem_instr  in  32  returned instruction word.
- imem_ready  in  1  instruction memory response valid.
- redirect_valid  in  1  single-cycle redirect strobe from execute.
- redirect_pc  in  ADDR_W  redirect target (word address).
- out_valid  out  1  FIFO head valid.
- out_instr  out  32  FIFO head instruction.
- out_pc  out  ADDR_W  address of FIFO head instruction.
- out_ready  in  1  decode accepts head this cycle.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, FIFO count=0, rd/wr pointers=0, state=IDLE, imem_rd_en=0, imem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=RESET_PC.
- Outputs are registered; imem_addr always equals the current pc register.
- Memory timing: the memory samples on the falling edge and raises imem_ready with data. A response is consumed at the first rising edge where imem_rd_en=1 and imem_ready=1. With the standard memory this is the end of the issue cycle, giving 1 word per cycle.
- imem_addr is held stable while imem_rd_en=1 and no response has been consumed.
- FSM states:
  - IDLE: rd_en=0. Go to FETCH when fetch_en=1 and count<DEPTH.
  - FETCH: rd_en=1. On a consumed response: push {instr, pc} and pc<=pc+1. Next state: IDLE if fetch_en=0; FULL if count after this edge is DEPTH; else FETCH.
  - FULL: rd_en=0. Go to FETCH (or IDLE if fetch_en=0) when count<DEPTH.
- Room rule: a request is only issued when count<DEPTH at the start of the cycle, so a push never overflows.
- fetch_en dropped while a request is outstanding: the current request completes, then IDLE.
- Pop: when out_valid && out_ready, the pointer advances and the next head appears the following cycle.
- Push and pop in the same cycle: count is unchanged. Push into an empty FIFO gives out_valid=1 the next cycle; there is no bypass.
- pc arithmetic: pc+1 modulo 2^ADDR_W; wraps from all-ones to 0 silently.
- Redirect (priority over everything):
  - At the edge where redirect_valid=1, the FIFO is flushed (count=0, pointers=0) and pc<=redirect_pc.
  - Any response consumed at that edge is discarded; a pop in that cycle is ignored.
  - State becomes FETCH if fetch_en=1, else IDLE. The first request to redirect_pc is driven the next cycle.
  - out_valid=0 for at least one cycle after a redirect.
- Reset mid-request: all state clears immediately and rd_en drops asynchronously.
- imem_ready while rd_en=0 is ignored.

Test Plan:
- Reset, fetch_en=1, out_ready=1, mem[i]=i+32'h100 → rd_en high from cycle 1; addr 0,1,2,… one per cycle; out stream (pc,instr)=(0,100),(1,101),… with no bubbles after the first.
- out_ready=0, DEPTH=4 → exactly 4 reads (addr 0–3), then FULL with rd_en=0 and addr=4. Raise out_ready → head pc=0, and fetch resumes at addr 4.
- Redirect to 32'h40 while the FIFO holds pc 5–7 and a response for pc 8 returns the same edge → pc8 dropped, out_valid=0 the next cycle; next outputs pc 40,41 with mem[40],mem[41].
- Slow memory model (ready 3 cycles after rd_en) → addr stable for all 3 cycles; one push per response; pc increments only on consumed responses.
- pc reset to 32'hFFFF_FFFE, free-running → addresses FFFF_FFFE, FFFF_FFFF, 0000_0000.
- Assert rst_n=0 mid-FETCH with FIFO count=3 → rd_en and out_valid go to 0 before the next edge; after release, fetching restarts at RESET_PC.
